// File: rtl/scroll_sequencer.sv
`default_nettype none
// ============================================================================
// scroll_sequencer : clear / fill / pad / rotate sequencer for the 7-seg shift
//                    register, with its own step timebase.   Rev 1.0
// ============================================================================
module scroll_sequencer #(
  parameter int TICK_CYCLES = 50_000_000,
  parameter int DIGITS      = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic       stop_i,
  input  logic       hold_i,
  input  logic       dir_i,
  input  logic [3:0] msg_len_i,
  output logic [3:0] char_index_o,
  output logic       load_o,
  output logic       blank_o,
  output logic       rotate_o,
  output logic       rot_dir_o,
  output logic       busy_o,
  output logic [2:0] current_state_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_FILL   = 3'd2,
    S_PAD    = 3'd3,
    S_SCROLL = 3'd4
  } state_e;

  localparam int            TW        = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
  localparam logic [3:0]    DIG_LAST  = 4'(DIGITS - 1);
  localparam logic [3:0]    DIG_NUM   = 4'(DIGITS);

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [3:0]    len_q, len_d;
  logic          dir_q, dir_d;

  logic          tick;
  logic [TW-1:0] tick_adv;

  // A step fires only on an unheld cycle at the top of the count.
  assign tick     = (tick_q == TICK_LAST) && !hold_i;
  assign tick_adv = hold_i ? tick_q : ((tick_q == TICK_LAST) ? '0 : tick_q + TW'(1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      tick_q  <= '0;
      len_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      len_q   <= len_d;
      dir_q   <= dir_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    tick_d       = tick_q;
    len_d        = len_q;
    dir_d        = dir_q;
    load_o       = 1'b0;
    blank_o      = 1'b0;
    rotate_o     = 1'b0;
    rot_dir_o    = 1'b0;
    char_index_o = '0;

    if (state_q != S_IDLE && stop_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      tick_d  = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start_i && msg_len_i != 4'd0) begin
            state_d = S_CLEAR;
            cnt_d   = '0;
            len_d   = (int'(msg_len_i) > DIGITS) ? DIG_NUM : msg_len_i;
            dir_d   = dir_i;
          end
        end
        S_CLEAR: begin
          load_o  = 1'b1;
          blank_o = 1'b1;
          if (cnt_q == DIG_LAST) begin
            state_d = S_FILL;
            cnt_d   = '0;
            tick_d  = '0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        S_FILL: begin
          char_index_o = cnt_q;
          tick_d       = tick_adv;
          if (tick) begin
            load_o = 1'b1;
            // The count carries on past L-1 so PAD can stop at DIGITS-1.
            cnt_d  = cnt_q + 4'd1;
            if (cnt_q == len_q - 4'd1) begin
              state_d = (len_q < DIG_NUM) ? S_PAD : S_SCROLL;
            end
          end
        end
        S_PAD: begin
          tick_d = tick_adv;
          if (tick) begin
            load_o  = 1'b1;
            blank_o = 1'b1;
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == DIG_LAST) begin
              state_d = S_SCROLL;
            end
          end
        end
        S_SCROLL: begin
          tick_d = tick_adv;
          if (tick) begin
            rotate_o  = 1'b1;
            rot_dir_o = dir_q;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
          tick_d  = '0;
        end
      endcase
    end
  end

  assign busy_o          = (state_q != S_IDLE);
  assign current_state_o = state_q;

endmodule
`default_nettype wire

// File: tb/tb_scroll_sequencer.sv
`default_nettype none
// ============================================================================
// tb_scroll_sequencer : directed bench with a step-arithmetic reference model.
//                       Rev 1.0
// ============================================================================
module tb_scroll_sequencer;
  localparam int T = 4;
  localparam int D = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, stop = 1'b0, hold = 1'b0, dir = 1'b0;
  logic [3:0] msg_len = 4'd0;
  logic [3:0] char_index;
  logic       load, blank, rotate, rot_dir, busy;
  logic [2:0] current_state;

  scroll_sequencer #(.TICK_CYCLES(T), .DIGITS(D)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .stop_i(stop), .hold_i(hold),
    .dir_i(dir), .msg_len_i(msg_len), .char_index_o(char_index), .load_o(load),
    .blank_o(blank), .rotate_o(rotate), .rot_dir_o(rot_dir), .busy_o(busy),
    .current_state_o(current_state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // Model: mode 0 idle, 1 clearing (m_c cycles done), 2 running with m_ac
  // unheld cycles since the clear finished. Step s = m_ac / T decides the phase.
  int m_mode = 0, m_c = 0, m_ac = 0, m_L = 0;
  bit m_dir = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_c = 0; m_ac = 0; m_L = 0; m_dir = 1'b0;
    end else begin
      case (m_mode)
        0: if (start && msg_len != 4'd0) begin
             m_mode = 1; m_c = 0; m_dir = dir;
             m_L = (int'(msg_len) > D) ? D : int'(msg_len);
           end
        1: if (stop) m_mode = 0;
           else begin
             m_c++;
             if (m_c == D) begin m_mode = 2; m_ac = 0; end
           end
        default: if (stop) m_mode = 0; else if (!hold) m_ac++;
      endcase
    end
  end

  always @(negedge clk) begin
    int s;
    bit fire;
    logic [2:0] es;
    logic eb, el, ebl, er, erd;
    logic [3:0] ei;
    logic [11:0] exp_v, got_v;
    es = 3'd0; eb = 1'b0; el = 1'b0; ebl = 1'b0; er = 1'b0; erd = 1'b0; ei = 4'd0;
    if (m_mode == 1) begin
      es = 3'd1; eb = 1'b1; el = !stop; ebl = !stop;
    end else if (m_mode == 2) begin
      s    = m_ac / T;
      es   = (s < m_L) ? 3'd2 : (s < D) ? 3'd3 : 3'd4;
      eb   = 1'b1;
      ei   = (es == 3'd2) ? 4'(s) : 4'd0;
      fire = !stop && !hold && (m_ac % T == T - 1);
      if (fire) begin
        if (s < m_L)  el = 1'b1;
        else if (s < D) begin el = 1'b1; ebl = 1'b1; end
        else begin er = 1'b1; erd = m_dir; end
      end
    end
    exp_v = {es, eb, el, ebl, er, erd, ei};
    got_v = {current_state, busy, load, blank, rotate, rot_dir, char_index};
    n_cmp++;
    if (got_v !== exp_v) begin
      n_bad++;
      $display("FAIL cycle %0d outputs {state,busy,load,blank,rot,rotdir,idx}: got %h expected %h",
               cyc, got_v, exp_v);
    end
  end

  // Event log used by the literal checks.
  int n_clr, n_pad, n_rot, n_rot_r, clr_first;
  int ch_idx[$];
  int ch_cyc[$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (load && blank && current_state == 3'd1) begin
        if (n_clr == 0) clr_first = cyc;
        n_clr++;
      end
      if (load && blank && current_state == 3'd3) n_pad++;
      if (load && !blank) begin ch_idx.push_back(int'(char_index)); ch_cyc.push_back(cyc); end
      if (rotate) begin n_rot++; if (rot_dir) n_rot_r++; end
    end
  end

  task automatic clear_log();
    n_clr = 0; n_pad = 0; n_rot = 0; n_rot_r = 0; clr_first = 0;
    ch_idx.delete(); ch_cyc.delete();
  endtask

  task automatic chk(input string name, input int got, input int exp_v);
    n_cmp++;
    if (got != exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp_v);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int len, input bit d);
    msg_len = 4'(len); dir = d; start = 1'b1;
    cycles(1);
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    cycles(1);
    stop = 1'b0;
  endtask

  task automatic wait_chars(input int n, input int budget);
    int k = 0;
    while (ch_idx.size() < n && k < budget) begin
      @(negedge clk); #1; k++;
    end
    chk("char load wait", (ch_idx.size() >= n) ? 1 : 0, 1);
  endtask

  initial begin
    int r0;
    clear_log();
    cycles(3);
    rst_n = 1'b1;
    cycles(20);
    chk("idle state", int'(current_state), 0);
    chk("idle busy", int'(busy), 0);

    // MsgLen=5, left: 8 clears, chars 0..4 every 4 cycles, 3 pads, rotates.
    clear_log();
    pulse_start(5, 1'b0);
    cycles(50);
    chk("clear loads", n_clr, 8);
    chk("char count", ch_idx.size(), 5);
    if (ch_idx.size() == 5) begin
      for (int i = 0; i < 5; i++) chk("char index", ch_idx[i], i);
      chk("first char delay", ch_cyc[0] - clr_first, 11);
      chk("char spacing", ch_cyc[4] - ch_cyc[0], 16);
    end
    chk("pad loads", n_pad, 3);
    chk("rotates", n_rot, 2);
    pulse_start(5, 1'b1);
    cycles(8);
    chk("rotdir after ignored start", n_rot_r, 0);
    do_stop();
    chk("state after stop", int'(current_state), 0);
    r0 = n_rot;
    cycles(12);
    chk("no rotate after stop", n_rot, r0);

    // Hold for 10 cycles right after CharIndex=1.
    clear_log();
    pulse_start(3, 1'b1);
    wait_chars(2, 40);
    @(posedge clk); #1;
    hold = 1'b1;
    cycles(10);
    hold = 1'b0;
    wait_chars(3, 30);
    if (ch_idx.size() >= 3) begin
      chk("index after hold", ch_idx[2], 2);
      chk("gap across hold", ch_cyc[2] - ch_cyc[1], 14);
    end
    cycles(30);
    chk("pad loads len3", n_pad, 5);
    chk("right rotates seen", (n_rot > 0) ? 1 : 0, 1);
    chk("rotdir right", n_rot_r, n_rot);
    do_stop();

    // MsgLen=0 is a no-op.
    clear_log();
    pulse_start(0, 1'b0);
    cycles(10);
    chk("len0 busy", int'(busy), 0);
    chk("len0 clears", n_clr, 0);

    // MsgLen=12 clamps to 8 chars and skips PAD.
    clear_log();
    pulse_start(12, 1'b0);
    wait_chars(8, 60);
    if (ch_idx.size() == 8)
      for (int i = 0; i < 8; i++) chk("clamped index", ch_idx[i], i);
    cycles(6);
    chk("no pad when full", n_pad, 0);
    chk("rotate after full", n_rot, 1);
    chk("scroll state", int'(current_state), 4);
    do_stop();

    // Reset asserted during a pad Load.
    clear_log();
    pulse_start(2, 1'b0);
    cycles(23);
    chk("in pad", int'(current_state), 3);
    chk("pad load active", int'(load), 1);
    rst_n = 1'b0;
    #1;
    chk("outputs cleared by reset",
        int'({current_state, busy, load, blank, rotate, rot_dir, char_index}), 0);
    cycles(2);
    rst_n = 1'b1;
    cycles(15);
    chk("idle after reset", int'(current_state), 0);
    chk("not busy after reset", int'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/scroll_sequencer.md
# scroll_sequencer

Controller that sequences the 8-digit character shift register behind the 7-segment displays. It clears the displays, loads a message of up to DIGITS characters one per step from the message store, pads with blanks, then rotates the register one position per step until stopped. It replaces the fixed HELLO state chain with a length- and direction-programmable sequencer. It also owns the 1 s step timebase.

## Interface
- TICK_CYCLES, 50_000_000, clock cycles per step (one step = one Load or Rotate)
- DIGITS, 8, number of display positions in the shift register
- Clock  in  1  system clock, all state on posedge
- Reset  in  1  asynchronous, active-low; forces IDLE and clears all counters immediately
- Start  in  1  level, sampled each edge; begins a sequence when in IDLE
- Stop  in  1  level; aborts any sequence back to IDLE
- Hold  in  1  level; freezes stepping while high
- Dir  in  1  rotate direction, 0 = left, 1 = right; latched at Start
- MsgLen  in  4  message length in characters
- CharIndex  out  4  message-store index of the character being loaded
- Load  out  1  one-cycle strobe: shift register shifts in a character
- Blank  out  1  qualifies Load: 1 = shift in blank code, 0 = character at CharIndex
- Rotate  out  1  one-cycle strobe: rotate register one position
- RotDir  out  1  latched Dir, valid whenever Rotate is high
- Busy  out  1  high in every state except IDLE
- CurrentState  out  3  state encoding: IDLE=0, CLEAR=1, FILL=2, PAD=3, SCROLL=4

## Operation
- Latched length L is MsgLen clamped to DIGITS. MsgLen=0 makes Start a no-op.
- IDLE
  - All strobes low; CharIndex=0.
  - Start=1 and MsgLen!=0 latches L and Dir, then moves to CLEAR.
- CLEAR
  - Load=1 and Blank=1 for DIGITS consecutive cycles, regardless of Hold.
  - Internal count runs 0..DIGITS-1.
  - After the last cycle, moves to FILL and zeroes the tick counter.
- Tick counter
  - Runs in FILL, PAD and SCROLL, counting 0..TICK_CYCLES-1 and wrapping.
  - tick = (count == TICK_CYCLES-1) and Hold=0.
  - While Hold=1 the counter does not advance and no strobe fires.
- FILL
  - On each tick: Load=1, Blank=0, CharIndex=k.
  - k starts at 0 and increments after each Load.
  - After the Load with k=L-1: moves to PAD if L<DIGITS, else to SCROLL.
- PAD
  - On each tick: Load=1, Blank=1.
  - Emits DIGITS-L blank Loads, then moves to SCROLL.
- SCROLL
  - On each tick: Rotate=1, RotDir=latched Dir.
  - Stays in SCROLL indefinitely.
- Stop
  - Stop=1 in any non-IDLE state moves to IDLE at the next edge.
  - Stop has priority over Hold, tick and state progression.
  - No strobe is asserted in the cycle Stop is sampled high.
- Other rules
  - Start, Dir and MsgLen are ignored while Busy.
  - Load and Rotate are never high in the same cycle.
  - Blank=0 whenever Load=0.

## Timing
- Reset values: state IDLE, every output 0, all counters 0.
- Load, Blank, Rotate and CharIndex are combinational decodes of registered state and counters, with no input-to-output path except Stop and Hold gating. Busy and CurrentState decode state only.
- Start handshake:
  - Start high at edge E0 puts the block in CLEAR in the cycle after E0.
  - Blank Loads occupy cycles E0+1 .. E0+DIGITS.
  - FILL is entered at edge E0+DIGITS, with tick counter=0.
  - The first character Load occurs TICK_CYCLES cycles after FILL entry; each following step is TICK_CYCLES cycles later.
- Hold:
  - Hold does not affect CLEAR.
  - Step spacing, excluding held cycles, is exactly TICK_CYCLES.
  - Releasing Hold resumes with the same CharIndex and counter value.
- Reset mid-operation: asynchronous, so outputs drop in the same cycle with no partial strobe afterward.
- Width rules: tick counter width is clog2(TICK_CYCLES); the load count is 4 bits.

## Test plan
All scenarios use TICK_CYCLES=4 and DIGITS=8.
- Reset pulse low, then high → CurrentState=0, Busy=0, all strobes 0 for 20 idle cycles.
- MsgLen=5, Dir=0, Start one cycle → required strobes in order:
  - 8 consecutive Load+Blank cycles;
  - then every 4 cycles, Loads with CharIndex 0,1,2,3,4 and Blank=0;
  - then 3 blank Loads;
  - then Rotate every 4 cycles with RotDir=0;
  - Busy=1 throughout.
- Hold high for 10 cycles in FILL after CharIndex=1 → no strobes while held; the next Load has CharIndex=2 and arrives 4 active cycles after the previous one.
- Stop high in SCROLL → CurrentState=0 next edge and no further Rotate. Start with Dir=1 issued during SCROLL is ignored: RotDir stays 0.
- MsgLen=0 with Start → stays IDLE. MsgLen=12 → 8 character Loads (CharIndex 0..7), PAD skipped, SCROLL entered directly.
- Reset low mid-PAD → all outputs 0 in the same cycle. After Reset is released, the block stays IDLE until the next Start.
